// File: rtl/debounce_ctrl.sv
// Multi-key push-button debouncer: 2-flop input synchronizers, one shared sample tick,
// and a per-key confirmation FSM that produces clean levels and one-cycle press/release strobes.
// Define DEBOUNCE_EXT_TICK_EN to take the sample tick from tick_in instead of the internal divider.
module debounce_ctrl #(
    parameter int NKEY     = 5,
    parameter int DIV_W    = 19,
    parameter int STABLE_N = 3
) (
    input  logic            clk,
    input  logic            clr,
`ifdef DEBOUNCE_EXT_TICK_EN
    input  logic            tick_in,
`endif
    input  logic [NKEY-1:0] key_raw,
    output logic [NKEY-1:0] key_level,
    output logic [NKEY-1:0] key_press,
    output logic [NKEY-1:0] key_release,
    output logic            tick
);

    typedef enum logic [1:0] {
        RELEASED        = 2'd0,
        CONFIRM_PRESS   = 2'd1,
        PRESSED         = 2'd2,
        CONFIRM_RELEASE = 2'd3
    } key_state_t;

    localparam logic [3:0] STABLE_CNT = 4'(STABLE_N);

    logic [NKEY-1:0] key_meta;
    logic [NKEY-1:0] key_sync;
    logic            tick_raw;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (clr) begin
            key_meta <= '0;
            key_sync <= '0;
        end else begin
            key_meta <= key_raw;
            key_sync <= key_meta;
        end
    end

`ifdef DEBOUNCE_EXT_TICK_EN
    // tick_sync[1:0] synchronize tick_in; tick_sync[2] holds the previous value for edge detection.
    logic [2:0] tick_sync;
    logic       tick_q;

    always_ff @(posedge clk) begin
        if (clr) begin
            tick_sync <= '0;
            tick_q    <= 1'b0;
        end else begin
            tick_sync <= {tick_sync[1:0], tick_in};
            tick_q    <= tick_sync[1] & ~tick_sync[2];
        end
    end

    assign tick_raw = tick_q;
`else
    logic [DIV_W-1:0] q;

    always_ff @(posedge clk) begin
        if (clr) begin
            q <= '0;
        end else begin
            q <= q + DIV_W'(1);
        end
    end

    assign tick_raw = &q;
`endif

    // Suppress the tick while clear is held so no FSM can advance during reset.
    assign tick = tick_raw & ~clr;

    for (genvar i = 0; i < NKEY; i++) begin : g_key
        key_state_t state;
        logic [3:0] cnt;
        logic       level_q;
        logic       press_q;
        logic       release_q;
        logic       s;

        assign s = key_sync[i];

        always_ff @(posedge clk) begin
            if (clr) begin
                state     <= RELEASED;
                cnt       <= '0;
                level_q   <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
            end else begin
                press_q   <= 1'b0;
                release_q <= 1'b0;
                if (tick) begin
                    case (state)
                        RELEASED: begin
                            if (s) begin
                                if (STABLE_N == 1) begin
                                    state   <= PRESSED;
                                    level_q <= 1'b1;
                                    press_q <= 1'b1;
                                end else begin
                                    state <= CONFIRM_PRESS;
                                    cnt   <= 4'd1;
                                end
                            end
                        end
                        CONFIRM_PRESS: begin
                            if (!s) begin
                                state <= RELEASED;
                                cnt   <= '0;
                            end else if (cnt + 4'd1 == STABLE_CNT) begin
                                state   <= PRESSED;
                                cnt     <= '0;
                                level_q <= 1'b1;
                                press_q <= 1'b1;
                            end else begin
                                cnt <= cnt + 4'd1;
                            end
                        end
                        PRESSED: begin
                            if (!s) begin
                                if (STABLE_N == 1) begin
                                    state     <= RELEASED;
                                    level_q   <= 1'b0;
                                    release_q <= 1'b1;
                                end else begin
                                    state <= CONFIRM_RELEASE;
                                    cnt   <= 4'd1;
                                end
                            end
                        end
                        CONFIRM_RELEASE: begin
                            if (s) begin
                                state <= PRESSED;
                                cnt   <= '0;
                            end else if (cnt + 4'd1 == STABLE_CNT) begin
                                state     <= RELEASED;
                                cnt       <= '0;
                                level_q   <= 1'b0;
                                release_q <= 1'b1;
                            end else begin
                                cnt <= cnt + 4'd1;
                            end
                        end
                        default: begin
                            state <= RELEASED;
                            cnt   <= '0;
                        end
                    endcase
                end
            end
        end

        assign key_level[i]   = level_q;
        assign key_press[i]   = press_q;
        assign key_release[i] = release_q;
    end

endmodule

// File: tb/tb_debounce_ctrl.sv
// Self-checking bench for debounce_ctrl (internal divider build, DIV_W=4, STABLE_N=3):
// a run-length reference model checked every cycle, plus hand-computed checkpoints.
module tb_debounce_ctrl;

    localparam int NKEY     = 5;
    localparam int DIV_W    = 4;
    localparam int STABLE_N = 3;
    localparam int PERIOD   = 1 << DIV_W;

    logic            clk = 1'b0;
    logic            clr = 1'b1;
    logic [NKEY-1:0] key_raw = 5'b10110;
    logic [NKEY-1:0] key_level;
    logic [NKEY-1:0] key_press;
    logic [NKEY-1:0] key_release;
    logic            tick;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    debounce_ctrl #(
        .NKEY    (NKEY),
        .DIV_W   (DIV_W),
        .STABLE_N(STABLE_N)
    ) dut (
        .clk        (clk),
        .clr        (clr),
        .key_raw    (key_raw),
        .key_level  (key_level),
        .key_press  (key_press),
        .key_release(key_release),
        .tick       (tick)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a key's level flips once STABLE_N consecutive tick samples of the
    // 2-cycle-delayed input disagree with it; ticks fall every PERIOD cycles after clear.
    int              m_n     = 0;
    bit              m_valid = 1'b0;
    logic [NKEY-1:0] m_s1, m_s2, m_level, m_press, m_rel;
    int              m_run [NKEY];

    always @(posedge clk) begin : model
        logic [NKEY-1:0] lvl, prs, rls;
        int              run [NKEY];
        if (clr) begin
            m_valid <= 1'b1;
            m_n     <= 0;
            m_s1    <= '0;
            m_s2    <= '0;
            m_level <= '0;
            m_press <= '0;
            m_rel   <= '0;
            for (int i = 0; i < NKEY; i++) m_run[i] <= 0;
        end else if (m_valid) begin
            lvl = m_level;
            prs = '0;
            rls = '0;
            for (int i = 0; i < NKEY; i++) run[i] = m_run[i];
            if (m_n % PERIOD == PERIOD - 1) begin
                for (int i = 0; i < NKEY; i++) begin
                    if (m_s2[i] != lvl[i]) begin
                        run[i]++;
                        if (run[i] == STABLE_N) begin
                            lvl[i] = ~lvl[i];
                            if (lvl[i]) prs[i] = 1'b1;
                            else        rls[i] = 1'b1;
                            run[i] = 0;
                        end
                    end else begin
                        run[i] = 0;
                    end
                end
            end
            m_level <= lvl;
            m_press <= prs;
            m_rel   <= rls;
            for (int i = 0; i < NKEY; i++) m_run[i] <= run[i];
            m_s2 <= m_s1;
            m_s1 <= key_raw;
            m_n  <= m_n + 1;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("tick", 32'(tick), 32'(!clr && (m_n % PERIOD == PERIOD - 1)));
            check("key_level", 32'(key_level), 32'(m_level));
            check("key_press", 32'(key_press), 32'(m_press));
            check("key_release", 32'(key_release), 32'(m_rel));
            check("press_release_exclusive", 32'(key_press & key_release), 32'd0);
        end
    end

    // Advance to the falling edge where k cycles have elapsed since clear fell.
    task automatic goto(input int k);
        int guard = 0;
        while (m_n < k && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        if (m_n < k) begin
            errors++;
            $display("FAIL goto_timeout: reached %0d expected %0d", m_n, k);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_level", 32'(key_level), 32'd0);
        check("reset_press", 32'(key_press), 32'd0);
        check("reset_release", 32'(key_release), 32'd0);
        check("reset_tick", 32'(tick), 32'd0);

        clr     = 1'b0;
        key_raw = 5'b00001;
        goto(14); check("pre_first_tick", 32'(tick), 32'd0);
        goto(15); check("first_tick", 32'(tick), 32'd1);
        goto(16); check("post_first_tick", 32'(tick), 32'd0);

        goto(47); check("press0_early", 32'(key_press), 32'd0);
        check("level0_early", 32'(key_level), 32'd0);
        goto(48); check("press0", 32'(key_press), 32'b00001);
        check("level0_set", 32'(key_level), 32'b00001);
        goto(49); check("press0_one_cycle", 32'(key_press), 32'd0);
        check("level0_held", 32'(key_level), 32'b00001);

        key_raw = 5'b00011;
        goto(80);
        key_raw = 5'b00001;
        goto(96); check("glitch1_no_level", 32'(key_level), 32'b00001);
        check("glitch1_no_press", 32'(key_press), 32'd0);

        goto(100);
        key_raw = 5'b00000;
        goto(128); check("confirm_release_level", 32'(key_level), 32'b00001);
        goto(143); check("release0_early", 32'(key_release), 32'd0);
        goto(144); check("release0", 32'(key_release), 32'b00001);
        check("level0_clear", 32'(key_level), 32'd0);
        goto(145); check("release0_one_cycle", 32'(key_release), 32'd0);

        key_raw = 5'b10001;
        goto(191); check("press04_early", 32'(key_press), 32'd0);
        goto(192); check("press04", 32'(key_press), 32'b10001);
        check("level04", 32'(key_level), 32'b10001);

        key_raw = 5'b10101;
        goto(225);
        clr = 1'b1;
        repeat (2) @(negedge clk);
        check("midreset_level", 32'(key_level), 32'd0);
        check("midreset_press", 32'(key_press), 32'd0);
        check("midreset_tick", 32'(tick), 32'd0);
        clr = 1'b0;
        goto(32); check("reconfirm_level", 32'(key_level), 32'd0);
        goto(47); check("reconfirm_press_early", 32'(key_press), 32'd0);
        goto(48); check("reconfirm_press", 32'(key_press), 32'b10101);
        check("reconfirm_level_set", 32'(key_level), 32'b10101);
        goto(49); check("reconfirm_press_one_cycle", 32'(key_press), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/debounce_ctrl.md
# debounce_ctrl

Multi-channel push-button debounce controller for the board's key inputs. It owns the debounce sampling tick and synchronizes every raw key. A per-key confirmation state machine produces clean key levels plus one-cycle press/release strobes for the downstream control logic. The block replaces ad-hoc use of a free-running divider bit: the divider, the sampling schedule and all per-key decisions live here.

## Interface
- NKEY, 5, number of independent key channels
- DIV_W, 19, sample-tick divider width; the internal tick fires once every 2^DIV_W clk cycles
- STABLE_N, 3, consecutive agreeing samples needed to change a key's state; legal range 1..15
- clk  in  1  system clock, all logic on posedge
- clr  in  1  reset, synchronous, active-high; when 1 at a posedge all state clears
- tick_in  in  1  external sample clock, present only with DEBOUNCE_EXT_TICK_EN
- key_raw  in  NKEY  asynchronous raw button inputs, 1 = pressed
- key_level  out  NKEY  debounced level per key, registered
- key_press  out  NKEY  one-cycle strobe when a key becomes confirmed pressed
- key_release  out  NKEY  one-cycle strobe when a key becomes confirmed released
- tick  out  1  one-cycle sample strobe, for debug and for bench alignment

## Operation
- Synchronizer: each key_raw bit passes through 2 flops, giving key_sync. All decisions use key_sync.
- Tick generator, default: a DIV_W-bit counter q increments every cycle and wraps. tick = 1 in the cycle q == all-ones.
- Per-key FSM, 2-bit state plus 4-bit cnt. It advances only in cycles with tick = 1 and holds otherwise.
- FSM states and transitions on tick:
  - RELEASED:
    - s = 1 → CONFIRM_PRESS with cnt = 1. If STABLE_N = 1, go directly to PRESSED instead and emit press.
    - s = 0 → stay.
  - CONFIRM_PRESS:
    - s = 1 → cnt+1. When cnt+1 == STABLE_N, go to PRESSED, emit press and clear cnt.
    - s = 0 → RELEASED with cnt = 0, no strobe.
  - PRESSED: mirror of RELEASED, using s = 0 → CONFIRM_RELEASE.
  - CONFIRM_RELEASE: mirror of CONFIRM_PRESS. Completion goes to RELEASED and emits release. s = 1 returns to PRESSED.
- key_level[i] = 1 in PRESSED and CONFIRM_RELEASE, 0 otherwise. It is registered and changes in the same cycle as the strobe.
- Channels are fully independent. Several keys may strobe in the same cycle.
- A press and a release strobe for the same key can never be active together.

## Timing
- Reset: q = 0, synchronizer flops = 0, all FSMs in RELEASED with cnt = 0. All outputs are 0 from the cycle after clr is sampled high.
- While clr = 1 no tick is issued and no strobe is issued.
- First internal tick occurs 2^DIV_W − 1 cycles after clr deasserts.
- Input-to-sync latency: 2 cycles.
- Strobe/level latency: registered, 1 cycle after the tick on which the STABLE_N-th agreeing sample is taken. The strobe is high for exactly 1 cycle.
- Minimum press latency: STABLE_N ticks after key_sync becomes stable.
- Reset mid-confirmation discards the partial count. A key held through reset must re-confirm over STABLE_N fresh ticks, then emits a new press.
- Wrap-around: the q wrap is exactly the tick cycle. cnt never exceeds STABLE_N − 1.

## Configuration
- DEBOUNCE_EXT_TICK_EN defined:
  - The internal divider is removed and the tick_in port exists.
  - tick_in is passed through a 2-flop synchronizer and a rising-edge detector. tick = 1 for one cycle, 3 cycles after the tick_in rising edge.
  - DIV_W is ignored.
- DEBOUNCE_EXT_TICK_EN undefined: the internal DIV_W-bit divider drives tick and there is no tick_in port.

## Test plan
All scenarios use DIV_W = 4 (tick every 16 cycles) and STABLE_N = 3 unless noted.
- clr = 1 for 2 cycles with arbitrary key_raw → key_level, key_press, key_release and tick all 0. First tick arrives 15 cycles after clr falls.
- Hold key_raw[0] = 1 → key_press[0] = 1 for exactly one cycle, 1 cycle after the 3rd tick that samples 1. key_level[0] = 1 from that cycle.
- key_raw[1] high for exactly 2 ticks, then low → no key_press[1] pulse, and key_level[1] stays 0.
- From PRESSED, drop key_raw[0] → key_release[0] pulse after the 3rd low sample. key_level[0] returns to 0 in the same cycle.
- Assert key_raw[0] and key_raw[4] in the same cycle → key_press = 5'b10001 in a single cycle.
- Assert clr during CONFIRM_PRESS with the key still held → no strobe, then a fresh press after 3 new ticks.
- With DEBOUNCE_EXT_TICK_EN, toggle tick_in every 10 cycles → tick pulses 3 cycles after each rising edge, and the press sequence matches the internal-tick behaviour.
